program_sequencer: RTL and testbench

- Instruction-fetch and operand-supply stage directly upstream of the ALU, in the clock cycle = instruction cycle architecture.
- Holds the program counter and drives the instruction-memory address.
- Splits the fetched word into opcode and argument, and reads the selected 8-bit register from an internal register bank.
- Consumes the ALU's combinational jump address and jump enable to select the next PC. A run/halt FSM controls execution.

---
 rtl/program_sequencer.sv | 107 ++++++++++
 tb/tb_program_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: PC, instruction split and register bank feeding the ALU.
// Runs one instruction per clock under a run/halt FSM.
`ifndef ARG_WIDTH
`define ARG_WIDTH 8
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif

module program_sequencer #(
  parameter logic [`ARG_WIDTH-1:0] LAST_ADDR =
    {`ARG_WIDTH{1'b1}},
  parameter int REG_COUNT = 8,
  parameter int REG_SEL_WIDTH = 3,
  parameter logic [`OPCODE_WIDTH-1:0] IDLE_OPCODE =
    {`OPCODE_WIDTH{1'b1}}
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                halt_req,
  output logic [`ARG_WIDTH-1:0]               imem_addr,
  input  logic [`OPCODE_WIDTH+`ARG_WIDTH-1:0] imem_data,
  output logic [`OPCODE_WIDTH-1:0]            opcode,
  output logic [`ARG_WIDTH-1:0]               argument,
  output logic [7:0]                          register,
  input  logic [`ARG_WIDTH-1:0]               jmp_addr,
  input  logic                                jmp_ce,
  input  logic                                reg_wr_en,
  input  logic [REG_SEL_WIDTH-1:0]            reg_wr_addr,
  input  logic [7:0]                          reg_wr_data,
  output logic                                running,
  output logic                                done,
  output logic [15:0]                         instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                state;
  logic [`ARG_WIDTH-1:0] pc;
  logic [15:0]           cnt;
  logic [7:0]            bank [REG_COUNT];

  logic [`ARG_WIDTH-1:0]    arg_f;
  logic [REG_SEL_WIDTH-1:0] sel;
  logic [15:0]              cnt_inc;

  assign arg_f = imem_data[`ARG_WIDTH-1:0];
  assign sel = arg_f[REG_SEL_WIDTH-1:0];
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
      for (int i = 0; i < REG_COUNT; i++)
        bank[i] <= 8'h00;
    end else begin
      if (reg_wr_en)
        bank[reg_wr_addr] <= reg_wr_data;
      unique case (state)
        RUN: begin
          cnt <= cnt_inc;
          // halt wins over a jump, a jump wins over end of program
          if (halt_req)
            state <= HALT;
          else if (jmp_ce)
            pc <= jmp_addr;
          else if (pc == LAST_ADDR)
            state <= HALT;
          else
            pc <= pc + 1'b1;
        end
        IDLE, HALT: begin
          if (start) begin
            state <= RUN;
            pc    <= '0;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    imem_addr = pc;
    opcode    = IDLE_OPCODE;
    argument  = '0;
    register  = 8'h00;
    if (state == RUN) begin
      opcode   = imem_data[`OPCODE_WIDTH+`ARG_WIDTH-1:`ARG_WIDTH];
      argument = arg_f;
      register = bank[sel];
    end
  end

  assign running     = (state == RUN);
  assign done        = (state == HALT);
  assign instr_count = cnt;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed program runs checked against a
// cycle model of the sequencer plus literal spot checks.
`ifndef ARG_WIDTH
`define ARG_WIDTH 8
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif

module tb_program_sequencer;

  localparam int AW = `ARG_WIDTH;
  localparam int OW = `OPCODE_WIDTH;
  localparam logic [AW-1:0] LAST = 4;
  localparam logic [OW-1:0] IDLE_OP = {OW{1'b1}};

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic          halt_req = 0;
  logic [AW-1:0] imem_addr;
  logic [OW+AW-1:0] imem_data;
  logic [OW-1:0] opcode;
  logic [AW-1:0] argument;
  logic [7:0]    register;
  logic [AW-1:0] jmp_addr = 0;
  logic          jmp_ce = 0;
  logic          reg_wr_en = 0;
  logic [2:0]    reg_wr_addr = 0;
  logic [7:0]    reg_wr_data = 0;
  logic          running;
  logic          done;
  logic [15:0]   instr_count;

  logic [OW+AW-1:0] rom [256];
  assign imem_data = rom[imem_addr];

  program_sequencer #(.LAST_ADDR(LAST)) dut (
    .clk(clk), .rst(rst), .start(start),
    .halt_req(halt_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .opcode(opcode),
    .argument(argument), .register(register),
    .jmp_addr(jmp_addr), .jmp_ce(jmp_ce),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .running(running),
    .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 0;

  // model: 0 idle, 1 run, 2 halt
  int          m_st = 0;
  int          m_pc = 0;
  int          m_cnt = 0;
  logic [7:0]  m_bank [8];

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_pc = 0; m_cnt = 0;
      foreach (m_bank[i]) m_bank[i] = 0;
    end else begin
      if (reg_wr_en) m_bank[reg_wr_addr] = reg_wr_data;
      if (m_st == 1) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (halt_req) m_st = 2;
        else if (jmp_ce) m_pc = int'(jmp_addr);
        else if (m_pc == int'(LAST)) m_st = 2;
        else m_pc = (m_pc + 1) % 256;
      end else if (start) begin
        m_st = 1; m_pc = 0; m_cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [OW+AW-1:0] w;
      logic [OW-1:0] e_op;
      logic [AW-1:0] e_arg;
      logic [7:0] e_reg;
      w = rom[m_pc];
      e_op = IDLE_OP; e_arg = 0; e_reg = 0;
      if (m_st == 1) begin
        e_op = w[OW+AW-1:AW];
        e_arg = w[AW-1:0];
        e_reg = m_bank[e_arg[2:0]];
      end
      chk("model_outputs",
          {imem_addr, opcode, argument, register,
           running, done, instr_count},
          {m_pc[AW-1:0], e_op, e_arg, e_reg,
           m_st == 1, m_st == 2, m_cnt[15:0]});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 0;
    rom[0] = {4'h1, 8'h01};
    rom[1] = {4'h2, 8'h02};
    rom[2] = {4'h3, 8'h02};
    rom[3] = {4'h4, 8'h03};
    rom[4] = {4'h5, 8'h04};
    rom[7] = {4'h6, 8'h07};

    cyc(2);
    rst = 0;
    check_en = 1;
    cyc(1);
    chk("rst_running", running, 0);
    chk("rst_opcode", opcode, IDLE_OP);
    chk("rst_count", instr_count, 0);
    chk("rst_addr", imem_addr, 0);

    reg_wr_en = 1; reg_wr_addr = 1; reg_wr_data = 5;
    cyc(1);
    reg_wr_addr = 2; reg_wr_data = 3;
    cyc(1);
    reg_wr_en = 0;

    start = 1;
    cyc(1);
    start = 0;
    chk("t1_addr", imem_addr, 0);
    chk("t1_op", opcode, 1);
    chk("t1_reg", register, 5);
    cyc(1);
    chk("t1_addr1", imem_addr, 1);
    chk("t1_reg1", register, 3);
    chk("t1_cnt1", instr_count, 1);

    cyc(1);
    jmp_ce = 1; jmp_addr = 7;
    cyc(1);
    jmp_ce = 0;
    chk("t2_addr", imem_addr, 7);
    chk("t2_cnt", instr_count, 3);
    halt_req = 1;
    cyc(1);
    halt_req = 0;
    chk("t2_done", done, 1);

    start = 1;
    cyc(1);
    start = 0;
    cyc(4);
    chk("t3_pc4", imem_addr, 4);
    cyc(1);
    chk("t3_done", done, 1);
    chk("t3_running", running, 0);
    chk("t3_op", opcode, IDLE_OP);
    chk("t3_cnt", instr_count, 5);
    chk("t3_addr", imem_addr, 4);

    start = 1;
    cyc(1);
    start = 0;
    cyc(3);
    halt_req = 1; jmp_ce = 1; jmp_addr = 1;
    cyc(1);
    halt_req = 0; jmp_ce = 0;
    chk("t4_done", done, 1);
    chk("t4_addr", imem_addr, 3);
    start = 1;
    cyc(1);
    start = 0;
    chk("t4_addr0", imem_addr, 0);
    chk("t4_cnt0", instr_count, 0);

    reg_wr_en = 1; reg_wr_addr = 2; reg_wr_data = 8'h11;
    cyc(1);
    chk("t5_old", register, 8'h11);
    reg_wr_data = 8'hA5; jmp_ce = 1; jmp_addr = 1;
    #2;
    chk("t5_nobypass", register, 8'h11);
    cyc(1);
    reg_wr_en = 0;
    chk("t5_new", register, 8'hA5);

    cyc(70000);
    chk("t6_sat", instr_count, 16'hFFFF);
    chk("t6_addr", imem_addr, 1);
    rst = 1; jmp_ce = 0;
    cyc(1);
    rst = 0;
    chk("t6_running", running, 0);
    chk("t6_addr0", imem_addr, 0);
    chk("t6_op", opcode, IDLE_OP);
    chk("t6_cnt", instr_count, 0);
    start = 1;
    cyc(1);
    start = 0;
    chk("t6_r1", register, 0);
    cyc(1);
    chk("t6_r2", register, 0);
    halt_req = 1;
    cyc(1);
    halt_req = 0;
    cyc(1);
    check_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
